// File: rtl/lsu_pkg.sv
// Shared encodings for the LSU request sequencer: LSU dtype codes, RISC-V funct3,
// FSM states, decoder payload and the split-load extension helper.
package lsu_pkg;

    localparam logic [2:0] BYTE               = 3'b000;
    localparam logic [2:0] HALF_WORD          = 3'b001;
    localparam logic [2:0] WORD               = 3'b010;
    localparam logic [2:0] BYTE_UNSIGNED      = 3'b011;
    localparam logic [2:0] HALF_WORD_UNSIGNED = 3'b100;
    localparam logic [2:0] DTYPE_IDLE         = 3'b111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0] dtype;
        logic       illegal;
        logic       misaligned;
        logic [2:0] nbytes;
    } dec_t;

    // Extend a byte-assembled split load according to its original funct3.
    function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_H:    return {{16{d[15]}}, d[15:0]};
            F3_HU:   return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_funct3_decode.sv
// Combinational decode of funct3/we/addr[1:0] into LSU dtype, legality,
// alignment and access size in bytes.
module lsu_funct3_decode
    import lsu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       we,
    input  logic [1:0] addr_lo,
    output dec_t       dec_c
);

    always_comb begin
        dec_c = '{dtype: DTYPE_IDLE, illegal: 1'b1, misaligned: 1'b0, nbytes: 3'd1};
        case (funct3)
            F3_B: begin
                dec_c.dtype   = BYTE;
                dec_c.illegal = 1'b0;
            end
            F3_H: begin
                dec_c.dtype      = HALF_WORD;
                dec_c.illegal    = 1'b0;
                dec_c.misaligned = addr_lo[0];
                dec_c.nbytes     = 3'd2;
            end
            F3_W: begin
                dec_c.dtype      = WORD;
                dec_c.illegal    = 1'b0;
                dec_c.misaligned = |addr_lo;
                dec_c.nbytes     = 3'd4;
            end
            F3_BU: begin
                if (!we) begin
                    dec_c.dtype   = BYTE_UNSIGNED;
                    dec_c.illegal = 1'b0;
                end
            end
            F3_HU: begin
                if (!we) begin
                    dec_c.dtype      = HALF_WORD_UNSIGNED;
                    dec_c.illegal    = 1'b0;
                    dec_c.misaligned = addr_lo[0];
                    dec_c.nbytes     = 3'd2;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_req_ctrl.sv
// Single-outstanding load/store sequencer in front of lsu: decode, issue, wait, respond.
// Optional LSU_MISALIGN_SPLIT_EN splits misaligned half/word accesses into byte accesses.
module lsu_req_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_SPACE = 4096,
    parameter int unsigned RD_LATENCY    = 1,
    localparam int unsigned AW           = $clog2(ADDRESS_SPACE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AW-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [AW-1:0]         lsu_addr,
    output logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_we,
    output logic [2:0]            lsu_dtype,
    input  logic [DATA_WIDTH-1:0] lsu_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    state_e                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  split_q, split_d;
    logic [1:0]            last_q, last_d;
    logic [1:0]            idx_q, idx_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rbuf_q, rbuf_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic [AW-1:0]         lsu_addr_q, lsu_addr_d;
    logic [DATA_WIDTH-1:0] lsu_data_q, lsu_data_d;
    logic                  lsu_we_q, lsu_we_d;
    logic [2:0]            lsu_dtype_q, lsu_dtype_d;

    dec_t                  dec_c;
    logic                  hs_c, req_err_c, req_split_c, rd_done_c, last_byte_c;
    logic [1:0]            idx_nx_c;
    logic [DATA_WIDTH-1:0] rbuf_c;

    lsu_funct3_decode u_decode (
        .funct3  (req_funct3),
        .we      (req_we),
        .addr_lo (req_addr[1:0]),
        .dec_c   (dec_c)
    );

    assign hs_c        = req_valid && req_ready_q;
    assign req_err_c   = dec_c.illegal | (dec_c.misaligned & ~SPLIT_EN);
    assign req_split_c = dec_c.misaligned & SPLIT_EN;
    assign rd_done_c   = (cnt_q == 2'(RD_LATENCY));
    assign last_byte_c = !split_q || (idx_q == last_q);
    assign idx_nx_c    = idx_q + 2'd1;

    // Split loads deposit each returned byte into its lane of the assembly buffer.
    always_comb begin
        rbuf_c = rbuf_q;
        rbuf_c[{idx_q, 3'b000} +: 8] = lsu_rdata[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (hs_c) state_d = req_err_c ? S_RESP : S_ISSUE;
            S_ISSUE: state_d = we_q ? (last_byte_c ? S_RESP : S_ISSUE) : S_WAIT;
            S_WAIT:  if (rd_done_c) state_d = last_byte_c ? S_RESP : S_ISSUE;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        split_d      = split_q;
        last_d       = last_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        rbuf_d       = rbuf_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        lsu_addr_d   = lsu_addr_q;
        lsu_data_d   = lsu_data_q;
        lsu_dtype_d  = lsu_dtype_q;
        lsu_we_d     = 1'b0;
        req_ready_d  = (state_d == S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (hs_c) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    split_d  = req_split_c;
                    last_d   = req_split_c ? 2'(dec_c.nbytes - 3'd1) : 2'd0;
                    idx_d    = 2'd0;
                    rbuf_d   = '0;
                    if (req_err_c) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        lsu_addr_d  = req_addr;
                        lsu_dtype_d = req_split_c ? (req_we ? BYTE : BYTE_UNSIGNED) : dec_c.dtype;
                        lsu_data_d  = req_split_c ? DATA_WIDTH'(req_wdata[7:0]) : req_wdata;
                        lsu_we_d    = req_we;
                    end
                end
            end
            S_ISSUE: begin
                if (!we_q) begin
                    cnt_d = 2'd1;
                end else if (last_byte_c) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                    lsu_dtype_d  = DTYPE_IDLE;
                end else begin
                    idx_d      = idx_nx_c;
                    lsu_addr_d = addr_q + AW'(idx_nx_c);
                    lsu_data_d = DATA_WIDTH'(wdata_q[{idx_nx_c, 3'b000} +: 8]);
                    lsu_we_d   = 1'b1;
                end
            end
            S_WAIT: begin
                if (!rd_done_c) begin
                    cnt_d = cnt_q + 2'd1;
                end else begin
                    rbuf_d = rbuf_c;
                    if (last_byte_c) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_rdata_d = split_q ? DATA_WIDTH'(ext_load(funct3_q, rbuf_c)) : lsu_rdata;
                        lsu_dtype_d  = DTYPE_IDLE;
                    end else begin
                        idx_d      = idx_nx_c;
                        lsu_addr_d = addr_q + AW'(idx_nx_c);
                    end
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            split_q      <= 1'b0;
            last_q       <= 2'd0;
            idx_q        <= 2'd0;
            cnt_q        <= 2'd0;
            rbuf_q       <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            lsu_addr_q   <= '0;
            lsu_data_q   <= '0;
            lsu_we_q     <= 1'b0;
            lsu_dtype_q  <= DTYPE_IDLE;
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            split_q      <= split_d;
            last_q       <= last_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            rbuf_q       <= rbuf_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            lsu_addr_q   <= lsu_addr_d;
            lsu_data_q   <= lsu_data_d;
            lsu_we_q     <= lsu_we_d;
            lsu_dtype_q  <= lsu_dtype_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign lsu_addr   = lsu_addr_q;
    assign lsu_data   = lsu_data_q;
    assign lsu_we     = lsu_we_q;
    assign lsu_dtype  = lsu_dtype_q;

endmodule

// File: doc/lsu_req_ctrl.md
Name: lsu_req_ctrl

Overview:
- Request sequencer sitting directly upstream of `lsu`, between the execute stage and the memory.
- Accepts one load/store per valid/ready handshake and translates RISC-V funct3 into the LSU dtype encoding.
- Checks alignment, drives the `lsu` address/data/WE/dtype inputs for the required cycles, captures read data after a fixed latency, and returns one response per request to writeback.

Parameters:
- DATA_WIDTH, 32, data path width; only 32 supported.
- ADDRESS_SPACE, 4096, byte address space; AW = $clog2(ADDRESS_SPACE).
- RD_LATENCY, 1, cycles from `lsu` address/dtype presented to `lsu` data_out valid; range 1..3.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  AW  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3.
- resp_valid  out  1  response valid.
- resp_ready  in  1  downstream accepts response.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal request.
- lsu_addr  out  AW  to lsu addr_in.
- lsu_data  out  DATA_WIDTH  to lsu data_in.
- lsu_we  out  1  to lsu WE_in.
- lsu_dtype  out  3  to lsu dtypes_in.
- lsu_rdata  in  DATA_WIDTH  from lsu data_out.

Behaviour:
- Clock and reset: one clock `clk`; `reset_n` is asynchronous, active-low.
- Reset values:
  - req_ready=0 during reset, 1 in IDLE thereafter.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - lsu_addr=0, lsu_data=0, lsu_we=0, lsu_dtype=3'b111 (idle code, LSU writes nothing).
- funct3 map, loads: 000→BYTE 000, 001→HALF 001, 010→WORD 010, 100→BYTE_U 011, 101→HALF_U 100; others illegal.
- funct3 map, stores: 000→000, 001→001, 010→010; others illegal.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On handshake, register addr/wdata/we/funct3.
  - Illegal or misaligned → RESP with resp_err=1 and no LSU activity; otherwise → ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive lsu_addr, lsu_dtype, lsu_data=wdata.
  - lsu_we=1 for stores only.
  - Store → RESP. Load → WAIT.
- WAIT:
  - lsu_addr/lsu_dtype held, lsu_we=0.
  - Counter runs RD_LATENCY cycles counted from the ISSUE cycle.
  - At the final cycle, capture lsu_rdata into resp_rdata → RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable until resp_valid && resp_ready → IDLE.
  - lsu_dtype returns to 3'b111.
- Latency:
  - Aligned store: resp_valid 2 cycles after the handshake edge.
  - Aligned load: 1+RD_LATENCY+1 cycles.
  - Error: 1 cycle.
- Throughput: one outstanding request; req_ready=0 outside IDLE. A new request is accepted no earlier than the cycle after the response handshake.
- resp_ready held high in RESP completes the response in one cycle. resp_ready while not in RESP is ignored.
- lsu_we is never asserted outside ISSUE and never asserted for loads or errors.
- Reset asserted mid-operation: all outputs go to their reset values immediately and the FSM returns to IDLE; the in-flight request is dropped without a response.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Without it: misaligned accesses return resp_err=1 as above.
- With it: a misaligned half or word is split into N=2 or 4 byte accesses.
  - Addresses addr+i, ascending, wrapping modulo ADDRESS_SPACE.
  - Each access gets its own ISSUE/WAIT.
  - Stores: lsu_dtype=BYTE, lsu_data=wdata[8i+:8].
  - Loads: lsu_dtype=BYTE_U; byte i lands in bits[8i+:8], then sign- or zero-extended per funct3.
  - One response after the last byte; resp_err=0.
  - Illegal funct3 still errors.
  - Aligned accesses are unaffected.

Decomposition:
- Package `lsu_pkg`:
  - LSU dtype localparams (BYTE..HALF_WORD_UNSIGNED, DTYPE_IDLE=3'b111).
  - funct3 constants.
  - FSM state enum.
- Sub-module `lsu_funct3_decode` (combinational): funct3 + we + addr[1:0] → dtype, illegal, misaligned, byte count.

Test Plan:
- Aligned SW then LW:
  - SW addr 0x010, data 0xDEADBEEF → lsu_we high exactly one cycle with dtype 010; resp_err=0.
  - LW 0x010 → resp_rdata=0xDEADBEEF, resp_valid at cycle 1+RD_LATENCY+1.
- Sign extension, after SW 0x0000_80F0 at 0x020:
  - LB 0x020 → 0xFFFFFFF0; LBU 0x020 → 0x000000F0.
  - LH 0x020 → 0xFFFF80F0; LHU 0x020 → 0x000080F0.
- Errors:
  - LW at 0x013 (no macro) → resp_err=1 after 1 cycle, lsu_we never asserted.
  - funct3=011 load → resp_err=1.
  - SB with funct3=100 → resp_err=1.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid/resp_rdata stable, req_ready=0, second req_valid not accepted until the cycle after the handshake.
- Reset mid-WAIT: deassert reset_n during WAIT → resp_valid=0 and lsu_dtype=111 immediately; after release, req_ready=1 and the next LW completes normally.
- LSU_MISALIGN_SPLIT_EN:
  - SW 0x11223344 at 0x0FFF → four byte writes to 0xFFF, 0x000, 0x001, 0x002 (wrap).
  - LW at 0x0FFF → 0x11223344, single response.
